// File: rtl/conv_stream.sv
// conv_stream: streaming KxK 2-D convolution over a raster-scan pixel stream.
// Transposed-form systolic array (K rows of K MAC stages joined by line delays),
// run-time loadable signed kernel, border masking, rescale and clip on output.
module conv_stream #(
    parameter int N     = 28,
    parameter int M     = 28,
    parameter int K     = 5,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wt_we,
    input  logic [$clog2(K*K)-1:0] wt_addr,
    input  logic signed [WW-1:0]   wt_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [DW-1:0]          pxl_in,
    output logic                   out_valid,
    output logic [DW-1:0]          pxl_out,
    output logic                   frame_done
);
    localparam int KK  = K * K;
    localparam int AW  = $clog2(KK);
    localparam int PW  = DW + WW + 1;
    localparam int ACC = PW + AW;
    localparam int LD  = N - K;
    localparam int CW  = $clog2(N);
    localparam int RW  = $clog2(M);

    logic signed [WW-1:0]  wt_q [KK];
    logic signed [ACC-1:0] s_q  [K][K];
    logic signed [ACC-1:0] s_d  [K][K];
    logic signed [ACC-1:0] feed [K];
    logic signed [ACC-1:0] res_q;
    logic [CW-1:0]         col_q, col_d, cur_col;
    logic [RW-1:0]         row_q, row_d, cur_row;
    logic                  qual;
    logic                  out_valid_q, frame_done_q;

    // Zero-extended pixel times signed weight, sign-extended to accumulator width.
    function automatic logic signed [ACC-1:0] mul(input logic [DW-1:0] p,
                                                  input logic signed [WW-1:0] w);
        logic signed [PW-1:0] pe, we, pr;
        pe = $signed({{(WW+1){1'b0}}, p});
        we = $signed({{(DW+1){w[WW-1]}}, w});
        pr = pe * we;
        return $signed({{AW{pr[PW-1]}}, pr});
    endfunction

    // Arithmetic rescale, then clip into the unsigned pixel range.
    function automatic logic [DW-1:0] clip(input logic signed [ACC-1:0] v);
        logic signed [ACC-1:0] sh;
        sh = v >>> SHIFT;
        if (sh[ACC-1]) return '0;
        if (sh > $signed({{(ACC-DW){1'b0}}, {DW{1'b1}}})) return '1;
        return sh[DW-1:0];
    endfunction

    // Kernel register file; out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < KK; k++) wt_q[k] <= '0;
        end else if (wt_we && ({1'b0, wt_addr} < (AW+1)'(KK))) begin
            wt_q[wt_addr] <= wt_data;
        end
    end

    // Position of the pixel being accepted, masking decision and next counters.
    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        qual    = (cur_row >= RW'(K-1)) && (cur_col >= CW'(K-1));
        col_d   = cur_col + CW'(1);
        row_d   = cur_row;
        if (cur_col == CW'(N-1)) begin
            col_d = '0;
            row_d = (cur_row == RW'(M-1)) ? '0 : cur_row + RW'(1);
        end
    end

    // MAC chain: each kernel row adds its products onto the upstream partial sum.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            s_d[i][0] = feed[i] + mul(pxl_in, wt_q[i*K]);
            for (int j = 1; j < K; j++) begin
                s_d[i][j] = s_q[i][j-1] + mul(pxl_in, wt_q[i*K+j]);
            end
        end
    end

    generate
        if (LD > 0) begin : g_ld
            logic signed [ACC-1:0] ld_q [K-1][LD];

            // Line delay between kernel rows; shifts only on accept.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int r = 0; r < K-1; r++)
                        for (int d = 0; d < LD; d++) ld_q[r][d] <= '0;
                end else if (in_valid) begin
                    for (int r = 0; r < K-1; r++) begin
                        ld_q[r][0] <= s_q[r][K-1];
                        for (int d = 1; d < LD; d++) ld_q[r][d] <= ld_q[r][d-1];
                    end
                end
            end

            // Row inputs come from the tail of the previous row's line delay.
            always_comb begin
                feed[0] = '0;
                for (int r = 1; r < K; r++) feed[r] = ld_q[r-1][LD-1];
            end
        end else begin : g_direct
            // Image as wide as the kernel: rows chain directly.
            always_comb begin
                feed[0] = '0;
                for (int r = 1; r < K; r++) feed[r] = s_q[r-1][K-1];
            end
        end
    endgenerate

    // Systolic registers advance only on accept; idle cycles hold everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) s_q[i][j] <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) s_q[i][j] <= s_d[i][j];
        end
    end

    // Counters, result capture for inside windows, valid and end-of-frame flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            res_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= in_valid && qual;
            frame_done_q <= in_valid && (cur_row == RW'(M-1)) && (cur_col == CW'(N-1));
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                if (qual) res_q <= s_d[K-1][K-1];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign pxl_out    = clip(res_q);

endmodule

// File: tb/tb_conv_stream.sv
// Bench for conv_stream (N=M=8, K=3): a frame-buffer window model predicts every
// output cycle for two instances (SHIFT=0 and SHIFT=3); directed frames cover
// identity, stalls, saturation, rescale, resync, async reset and live weight writes.
module tb_conv_stream;
    localparam int NB = 8;
    localparam int MB = 8;
    localparam int KB = 3;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              wt_we    = 1'b0;
    logic [3:0]        wt_addr  = '0;
    logic signed [7:0] wt_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_sof   = 1'b0;
    logic [7:0]        pxl_in   = '0;
    logic              out_valid, frame_done, ov_s, fd_s;
    logic [7:0]        pxl_out, px_s;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    conv_stream #(.N(NB), .M(MB), .K(KB), .DW(8), .WW(8), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .in_valid(in_valid), .in_sof(in_sof), .pxl_in(pxl_in),
        .out_valid(out_valid), .pxl_out(pxl_out), .frame_done(frame_done));

    conv_stream #(.N(NB), .M(MB), .K(KB), .DW(8), .WW(8), .SHIFT(3)) dut_s (
        .clk(clk), .reset(reset), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .in_valid(in_valid), .in_sof(in_sof), .pxl_in(pxl_in),
        .out_valid(ov_s), .pxl_out(px_s), .frame_done(fd_s));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int mw [9] = '{default: 0};
    int img [MB][NB];
    int ws  [MB][NB][9];
    int mr = 0, mc = 0, cr, cc, acc;
    int exp_v = 0, exp_d = 0, exp_p = 0, exp_ps = 0;

    function automatic int clipb(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mr = 0; mc = 0;
            exp_v = 0; exp_d = 0; exp_p = 0; exp_ps = 0;
            for (int k = 0; k < 9; k++) mw[k] = 0;
        end else begin
            exp_v = 0;
            exp_d = 0;
            if (in_valid) begin
                cr = in_sof ? 0 : mr;
                cc = in_sof ? 0 : mc;
                img[cr][cc] = int'(pxl_in);
                for (int k = 0; k < 9; k++) ws[cr][cc][k] = mw[k];
                if (cr >= KB-1 && cc >= KB-1) begin
                    acc = 0;
                    for (int i = 0; i < KB; i++)
                        for (int j = 0; j < KB; j++)
                            acc += ws[cr-KB+1+i][cc-KB+1+j][i*KB+j] * img[cr-KB+1+i][cc-KB+1+j];
                    exp_v  = 1;
                    exp_p  = clipb(acc);
                    exp_ps = clipb(acc >>> 3);
                    exp_d  = (cr == MB-1 && cc == NB-1) ? 1 : 0;
                end
                mc = cc + 1;
                mr = cr;
                if (mc == NB) begin
                    mc = 0;
                    mr = (cr == MB-1) ? 0 : cr + 1;
                end
            end
            if (wt_we && wt_addr < 9) mw[wt_addr] = int'(wt_data);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    int n_ov = 0, n_fd = 0, n_nz = 0, first_v = -1, last_v = -1, last_s = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", int'(out_valid), exp_v);
            check("frame_done", int'(frame_done), exp_d);
            check("pxl_out", int'(pxl_out), exp_p);
            check("out_valid_s", int'(ov_s), exp_v);
            check("frame_done_s", int'(fd_s), exp_d);
            check("pxl_out_s", int'(px_s), exp_ps);
            if (out_valid) begin
                if (n_ov == 0) first_v = int'(pxl_out);
                last_v = int'(pxl_out);
                last_s = int'(px_s);
                if (pxl_out != 0) n_nz++;
                n_ov++;
            end
            if (frame_done) n_fd++;
        end
    end

    task automatic clear_stats();
        n_ov = 0; n_fd = 0; n_nz = 0; first_v = -1; last_v = -1; last_s = -1;
    endtask

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input int p, input bit sof, input bit we, input int a, input int d);
        @(negedge clk);
        in_valid = 1'b1; in_sof = sof; pxl_in = p[7:0];
        wt_we = we; wt_addr = a[3:0]; wt_data = d[7:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0; wt_we = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wt_we = 1'b1; wt_addr = a[3:0]; wt_data = d[7:0];
        @(posedge clk);
        #1;
        wt_we = 1'b0;
    endtask

    task automatic set_all(input int d);
        for (int k = 0; k < 9; k++) wr(k, d);
    endtask

    function automatic int pv(input int mode, input int r, input int c);
        case (mode)
            0:       return 8*r + c;
            1:       return 255;
            2:       return 16;
            default: return (r*37 + c*11 + 5) % 256;
        endcase
    endfunction

    task automatic frame(input int mode, input int gap, input int npix, input bit sof);
        for (int n = 0; n < npix; n++) begin
            while ($urandom_range(0, 99) < gap) idle(1);
            beat(pv(mode, n / NB, n % NB), sof && (n == 0), 1'b0, 0, 0);
        end
    endtask

    task automatic load_identity();
        set_all(0);
        wr(4, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pxl_out", int'(pxl_out), 0);
        check("rst_frame_done", int'(frame_done), 0);
        idle(2);
        reset = 1'b1;

        // Identity kernel, gapless ramp; address 12 is out of range and ignored.
        load_identity();
        wr(12, 9);
        clear_stats();
        frame(0, 0, 64, 1'b1);
        idle(3);
        check("id_count", n_ov, 36);
        check("id_done", n_fd, 1);
        check("id_first", first_v, 9);
        check("id_last", last_v, 54);

        // Same ramp, no sof (counter wrap), heavy random stalls.
        clear_stats();
        frame(0, 45, 64, 1'b0);
        idle(3);
        check("stall_count", n_ov, 36);
        check("stall_done", n_fd, 1);
        check("stall_first", first_v, 9);
        check("stall_last", last_v, 54);

        // Saturation high and low.
        set_all(127);
        clear_stats();
        frame(1, 0, 64, 1'b1);
        idle(3);
        check("sat_first", first_v, 255);
        check("sat_last", last_v, 255);
        check("sat_last_s", last_s, 255);
        set_all(-1);
        clear_stats();
        frame(1, 0, 64, 1'b1);
        idle(3);
        check("neg_count", n_ov, 36);
        check("neg_nonzero", n_nz, 0);

        // Rescale: 9*16 = 144, >>>3 = 18.
        set_all(1);
        clear_stats();
        frame(2, 0, 64, 1'b1);
        idle(3);
        check("rescale_s", last_s, 18);
        check("rescale_raw", last_v, 144);

        // Resync: abort mid row 4, restart with sof. Kernel k-4 on a ramp gives 150 everywhere.
        for (int k = 0; k < 9; k++) wr(k, k - 4);
        frame(3, 0, 35, 1'b1);
        idle(2);
        clear_stats();
        frame(0, 30, 64, 1'b1);
        idle(3);
        check("resync_count", n_ov, 36);
        check("resync_done", n_fd, 1);
        check("resync_first", first_v, 150);
        check("resync_last", last_v, 150);
        check("resync_nonzero", n_nz, 36);

        // Async reset mid-frame, inspected during the clock low phase.
        load_identity();
        frame(0, 0, 20, 1'b1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_pxl_out", int'(pxl_out), 0);
        check("arst_frame_done", int'(frame_done), 0);
        check("arst_out_valid_s", int'(ov_s), 0);
        check("arst_pxl_out_s", int'(px_s), 0);
        @(negedge clk);
        reset = 1'b1;

        // Weights cleared: a busy image with no sof yields all-zero outputs.
        clear_stats();
        frame(3, 0, 64, 1'b0);
        idle(3);
        check("postrst_count", n_ov, 36);
        check("postrst_nonzero", n_nz, 0);

        // Reload and rerun.
        load_identity();
        clear_stats();
        frame(0, 0, 64, 1'b1);
        idle(3);
        check("reload_first", first_v, 9);
        check("reload_last", last_v, 54);

        // Weight write in the same cycle as an accept, mid-frame.
        clear_stats();
        for (int n = 0; n < 64; n++)
            beat(pv(0, n / NB, n % NB), n == 0, n == 30, 4, 2);
        idle(3);
        check("live_wt_count", n_ov, 36);
        check("live_wt_last", last_v, 108);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_stream.md
# conv_stream

Parametrised streaming 2-D convolution engine: one raster-scan pixel per accepted beat, a K×K signed kernel loaded at run time, and one clipped output pixel per fully-inside window. It is the next generation of the fixed 5×5 edge-detect convolver in the FPGA image path. It adds programmable weights, input valid gating with stalls, frame resynchronisation, border masking, output rescaling and an end-of-frame indication. It sits between the pixel source and the downstream pooling/readout logic.

## Interface
- N, 28, image columns (≥ K)
- M, 28, image rows (≥ K)
- K, 5, kernel size (odd or even, 2..7)
- DW, 8, pixel width (unsigned)
- WW, 8, weight width (signed two's complement)
- SHIFT, 0, arithmetic right shift applied to the sum before clipping
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- wt_we  in  1  weight write strobe
- wt_addr  in  clog2(K*K)  weight index = i*K + j (i = kernel row, j = kernel column)
- wt_data  in  WW  signed weight value
- in_valid  in  1  pxl_in is valid this cycle (accept); no backpressure
- in_sof  in  1  qualifies with in_valid; the accepted pixel is (row 0, col 0)
- pxl_in  in  DW  input pixel, raster order
- out_valid  out  1  pxl_out is valid this cycle
- pxl_out  out  DW  clipped, rescaled convolution result
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame

## Operation
- Transposed-form systolic array, identical in structure to the existing convolver: K rows of K MAC+register stages, with an (N−K)-deep line delay between rows. Every register and line-delay stage advances only on accept (in_valid=1). On idle cycles all state holds.
- Weights: K*K registers, reset to 0. A write with wt_we=1 updates wt[wt_addr] at the clock edge. Writes to addresses ≥ K*K are ignored. Each MAC uses the weight value present at the accept cycle. Weights are to be loaded between frames; a mid-frame write produces mixed-kernel results, and that is not an error.
- Arithmetic: the accumulator is signed, ACC = DW+WW+1+clog2(K*K) bits. Each product is the zero-extended pxl_in × signed weight, and no overflow is possible.
- Result = sum over i,j of wt[i*K+j] · p[r−K+1+i][c−K+1+j]. The result is then shifted right arithmetically by SHIFT and clipped: a negative value becomes 0, and a value > 2^DW−1 becomes 2^DW−1.
- Position counters col (0..N−1) and row (0..M−1) advance on accept.
  - col wraps to 0 after N−1, and row increments on that wrap.
  - After (M−1, N−1), the counters wrap to (0, 0).
  - Accepting with in_sof=1 forces the current pixel to be (0, 0), regardless of the counters.
- Border masking: an output is produced only for accepted pixels with row ≥ K−1 and col ≥ K−1. This gives (M−K+1)·(N−K+1) outputs per frame. Stale partial sums from a previous frame or an aborted frame are provably flushed by then, so no pipeline clear is needed on in_sof.

## Timing
- Latency: pixel (r, c) accepted at edge t gives out_valid=1 and its result on pxl_out during the cycle after t. The output is registered, and pxl_out is driven combinationally from the final register only through the clip logic.
- out_valid is high for exactly one cycle per qualifying accept. Back-to-back accepts give a continuous out_valid.
- pxl_out holds its last value while out_valid=0.
- frame_done = out_valid for position (M−1, N−1).
- Reset values: out_valid=0, frame_done=0, pxl_out=0, counters=(0,0), all accumulator and line-delay registers=0, weights=0.
- Reset asserted mid-frame aborts immediately. The weights must be reloaded afterwards, and the next accepted pixel is (0, 0).
- wt_we and in_valid in the same cycle is legal: the accepting MAC uses the old weight, and the new weight takes effect from the next accept.
- in_sof asserted on a pixel that would otherwise be (0, 0) has no additional effect.

## Test plan
- Identity load: N=M=8, K=3, wt[4]=1, others 0, SHIFT=0, pixel value = 8r+c streamed without gaps → 36 outputs, the output for (r, c) equals 8(r−1)+(c−1). The first output appears the cycle after pixel (2, 2) is accepted, and frame_done pulses with the output for (7, 7).
- Stall insertion: the same stream with random in_valid gaps (≥30% idle) → an identical output sequence, and out_valid only on the cycle after a qualifying accept.
- Saturation: all weights 127, all pixels 255, K=3 → every pxl_out=255. With all weights −1, every output is 0.
- Rescale: SHIFT=3, all weights 1, K=3, constant pixel 16 → sum 144 gives pxl_out=18.
- Resync: abort frame 1 mid-row 4 with in_sof on a new frame (ramp image) → frame 2 outputs exactly match a clean run, and frame 2 has 36 outputs.
- Async reset mid-frame, checked during the low phase: all outputs are 0 and the weights read back as 0. After reload, a full frame matches the golden model.
